// File: rtl/conv_pkg.sv
// Shared types and address helpers for the convolution PE sequencer.
// Pure declarations: no logic, no latency, no flow control.
package conv_pkg;

    localparam int PSUM_W = 32;

    typedef logic signed [1:0] tern_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

    function automatic int unsigned wt_addr_f(
        input int unsigned c,
        input int unsigned ky,
        input int unsigned kx,
        input int unsigned k
    );
        return c * k * k + ky * k + kx;
    endfunction

    function automatic int unsigned ifm_addr_f(
        input int unsigned c,
        input int unsigned ky,
        input int unsigned kx,
        input int unsigned oy,
        input int unsigned ox,
        input int unsigned h,
        input int unsigned w
    );
        return c * h * w + (oy + ky) * w + (ox + kx);
    endfunction

endpackage

// File: rtl/conv_tap_counter.sv
// Nested c/ky/kx tap counters (kx fastest) with last-tap flag and memory addresses.
// Addresses are combinational from the counter flops; clr beats en; holds when en=0.
module conv_tap_counter #(
    parameter int K      = 3,
    parameter int C      = 1,
    parameter int IMG_H  = 32,
    parameter int IMG_W  = 32,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [ADDR_W-1:0] oy,
    input  logic [ADDR_W-1:0] ox,
    output logic              last,
    output logic [ADDR_W-1:0] wt_addr,
    output logic [ADDR_W-1:0] ifm_addr
);
    import conv_pkg::*;

    localparam int KW = (K > 1) ? $clog2(K) : 1;
    localparam int CW = (C > 1) ? $clog2(C) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(K - 1);
    localparam logic [CW-1:0] C_LAST = CW'(C - 1);

    logic [KW-1:0] kx_q, kx_d;
    logic [KW-1:0] ky_q, ky_d;
    logic [CW-1:0] c_q, c_d;

    always_comb begin
        kx_d = kx_q;
        ky_d = ky_q;
        c_d  = c_q;
        if (clr) begin
            kx_d = '0;
            ky_d = '0;
            c_d  = '0;
        end else if (en) begin
            if (kx_q != K_LAST) begin
                kx_d = kx_q + 1'b1;
            end else begin
                kx_d = '0;
                if (ky_q != K_LAST) begin
                    ky_d = ky_q + 1'b1;
                end else begin
                    ky_d = '0;
                    c_d  = (c_q == C_LAST) ? '0 : c_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            kx_q <= '0;
            ky_q <= '0;
            c_q  <= '0;
        end else begin
            kx_q <= kx_d;
            ky_q <= ky_d;
            c_q  <= c_d;
        end
    end

    assign last     = (kx_q == K_LAST) && (ky_q == K_LAST) && (c_q == C_LAST);
    assign wt_addr  = ADDR_W'(wt_addr_f(32'(c_q), 32'(ky_q), 32'(kx_q), K));
    assign ifm_addr = ADDR_W'(ifm_addr_f(32'(c_q), 32'(ky_q), 32'(kx_q),
                                         32'(oy), 32'(ox), IMG_H, IMG_W));

endmodule

// File: rtl/conv_pe_sequencer.sv
// Drives one ternary PE through a valid stride-1 convolution, one pixel per K*K*C taps.
// T+1 cycles from RUN entry to out_valid; OUT holds pixel and addresses until out_ready.
module conv_pe_sequencer #(
    parameter int K      = 3,
    parameter int C      = 1,
    parameter int IMG_H  = 32,
    parameter int IMG_W  = 32,
    parameter int ADDR_W = 16,
    parameter int PSUM_W = conv_pkg::PSUM_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] wt_addr,
    output logic [ADDR_W-1:0] ifm_addr,
    input  logic [1:0]        wt_rdata,
    input  logic [1:0]        ifm_rdata,
    output logic [PSUM_W-1:0] pe_inpsum,
    output logic [1:0]        pe_weight,
    output logic [1:0]        pe_infmap,
    input  logic [PSUM_W-1:0] pe_outpsum,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PSUM_W-1:0] out_data,
    output logic [15:0]       zero_cnt
);
    import conv_pkg::*;

    localparam int OH = IMG_H - K + 1;
    localparam int OW = IMG_W - K + 1;
    localparam int YW = (OH > 1) ? $clog2(OH) : 1;
    localparam int XW = (OW > 1) ? $clog2(OW) : 1;
    localparam logic [YW-1:0] OY_LAST = YW'(OH - 1);
    localparam logic [XW-1:0] OX_LAST = XW'(OW - 1);

    state_e            state_q, state_d;
    logic              issued_q, issued_d;
    logic              tap_valid_q, tap_valid_d;
    logic              done_q, done_d;
    logic [PSUM_W-1:0] acc_q, acc_d;
    logic [PSUM_W-1:0] out_data_q, out_data_d;
    logic [15:0]       zero_cnt_q, zero_cnt_d;
    logic [YW-1:0]     oy_q, oy_d;
    logic [XW-1:0]     ox_q, ox_d;

    logic  tap_clr, tap_en, tap_last;
    logic  handshake, last_pix;
    tern_t ifm_v;

    assign ifm_v     = tern_t'(ifm_rdata);
    assign handshake = (state_q == ST_OUT) && out_ready;
    assign last_pix  = (oy_q == OY_LAST) && (ox_q == OX_LAST);

    always_comb begin
        state_d     = state_q;
        issued_d    = issued_q;
        tap_valid_d = 1'b0;
        done_d      = 1'b0;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        zero_cnt_d  = zero_cnt_q;
        oy_d        = oy_q;
        ox_d        = ox_q;
        tap_clr     = 1'b0;
        tap_en      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                acc_d      = '0;
                zero_cnt_d = '0;
                issued_d   = 1'b0;
                tap_clr    = 1'b1;
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Issue phase: the last tap parks the counter so its address stays put.
                tap_valid_d = !issued_q;
                if (!issued_q) begin
                    if (tap_last) begin
                        issued_d = 1'b1;
                    end else begin
                        tap_en = 1'b1;
                    end
                end
                if (tap_valid_q) begin
                    acc_d = pe_outpsum;
                    if (ifm_v == '0 && zero_cnt_q != 16'hFFFF) begin
                        zero_cnt_d = zero_cnt_q + 16'd1;
                    end
                    if (issued_q) begin
                        out_data_d = pe_outpsum;
                        state_d    = ST_OUT;
                    end
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    acc_d    = '0;
                    issued_d = 1'b0;
                    tap_clr  = 1'b1;
                    if (last_pix) begin
                        oy_d    = '0;
                        ox_d    = '0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_RUN;
                        if (ox_q == OX_LAST) begin
                            ox_d = '0;
                            oy_d = oy_q + 1'b1;
                        end else begin
                            ox_d = ox_q + 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            issued_q    <= 1'b0;
            tap_valid_q <= 1'b0;
            done_q      <= 1'b0;
            acc_q       <= '0;
            out_data_q  <= '0;
            zero_cnt_q  <= '0;
            oy_q        <= '0;
            ox_q        <= '0;
        end else begin
            state_q     <= state_d;
            issued_q    <= issued_d;
            tap_valid_q <= tap_valid_d;
            done_q      <= done_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            zero_cnt_q  <= zero_cnt_d;
            oy_q        <= oy_d;
            ox_q        <= ox_d;
        end
    end

    conv_tap_counter #(
        .K      (K),
        .C      (C),
        .IMG_H  (IMG_H),
        .IMG_W  (IMG_W),
        .ADDR_W (ADDR_W)
    ) u_tap_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (tap_clr),
        .en       (tap_en),
        .oy       (ADDR_W'(oy_q)),
        .ox       (ADDR_W'(ox_q)),
        .last     (tap_last),
        .wt_addr  (wt_addr),
        .ifm_addr (ifm_addr)
    );

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign out_valid = (state_q == ST_OUT);
    assign out_data  = out_data_q;
    assign zero_cnt  = zero_cnt_q;
    assign pe_inpsum = acc_q;
    assign pe_weight = wt_rdata;
    assign pe_infmap = ifm_rdata;

endmodule

// File: tb/tb_conv_pe_sequencer.sv
// Directed bench: 3x3 kernel over a 4x4 map with behavioural PE and 1-cycle memories.
module tb_conv_pe_sequencer;
    localparam int K   = 3;
    localparam int C   = 1;
    localparam int H   = 4;
    localparam int W   = 4;
    localparam int AW  = 16;
    localparam int PW  = 32;
    localparam int OW  = W - K + 1;
    localparam int NPX = (H - K + 1) * OW;
    localparam int T   = K * K * C;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          out_ready = 1'b1;
    logic          busy, done, out_valid;
    logic [AW-1:0] wt_addr, ifm_addr;
    logic [1:0]    wt_rdata, ifm_rdata, pe_weight, pe_infmap;
    logic [PW-1:0] pe_inpsum, pe_outpsum, out_data;
    logic [15:0]   zero_cnt;
    logic [1:0]    wt_mem [16];
    logic [1:0]    ifm_mem[16];
    int            n_chk = 0;
    int            n_err = 0;
    int            pw, pi;

    conv_pe_sequencer #(
        .K(K), .C(C), .IMG_H(H), .IMG_W(W), .ADDR_W(AW), .PSUM_W(PW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .wt_addr    (wt_addr),
        .ifm_addr   (ifm_addr),
        .wt_rdata   (wt_rdata),
        .ifm_rdata  (ifm_rdata),
        .pe_inpsum  (pe_inpsum),
        .pe_weight  (pe_weight),
        .pe_infmap  (pe_infmap),
        .pe_outpsum (pe_outpsum),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .zero_cnt   (zero_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        wt_rdata  <= wt_mem[wt_addr[3:0]];
        ifm_rdata <= ifm_mem[ifm_addr[3:0]];
    end

    always_comb begin
        pw = int'($signed(pe_weight));
        pi = int'($signed(pe_infmap));
    end
    assign pe_outpsum = pe_inpsum + PW'(pw * pi);

    task automatic check_eq(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int gold_px(input int oy, input int ox);
        int s = 0;
        for (int c = 0; c < C; c++)
            for (int ky = 0; ky < K; ky++)
                for (int kx = 0; kx < K; kx++)
                    s += int'($signed(wt_mem[c*K*K + ky*K + kx])) *
                         int'($signed(ifm_mem[c*H*W + (oy+ky)*W + ox + kx]));
        return s;
    endfunction

    function automatic int gold_zc();
        int z = 0;
        for (int p = 0; p < NPX; p++)
            for (int c = 0; c < C; c++)
                for (int ky = 0; ky < K; ky++)
                    for (int kx = 0; kx < K; kx++)
                        if (ifm_mem[c*H*W + (p/OW+ky)*W + p%OW + kx] == 2'b00) z++;
        return z;
    endfunction

    task automatic run_frame(input string tag, input int exp_px[NPX], input int exp_zc,
                             input bit started, input int stall_px, input int rst_px,
                             input int busy_start_px, input bit chain);
        int cyc;
        if (!started) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        check_eq({tag, "/busy_run"}, int'(busy), 1);
        for (int p = 0; p < NPX; p++) begin
            cyc = 0;
            while (!out_valid && cyc < 64) begin
                if (p == rst_px && cyc == 4) begin
                    rst_n = 1'b0;
                    @(negedge clk);
                    check_eq({tag, "/rst_busy"}, int'(busy), 0);
                    check_eq({tag, "/rst_valid"}, int'(out_valid), 0);
                    check_eq({tag, "/rst_zc"}, int'(zero_cnt), 0);
                    check_eq({tag, "/rst_wt_addr"}, int'(wt_addr), 0);
                    check_eq({tag, "/rst_ifm_addr"}, int'(ifm_addr), 0);
                    check_eq({tag, "/rst_data"}, int'($signed(out_data)), 0);
                    rst_n = 1'b1;
                    @(negedge clk);
                    return;
                end
                if (p == busy_start_px && cyc == 3) start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                cyc++;
            end
            check_eq($sformatf("%s/lat%0d", tag, p), cyc, T + 1);
            check_eq($sformatf("%s/px%0d", tag, p), int'($signed(out_data)), exp_px[p]);
            if (p == stall_px) begin
                out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check_eq({tag, "/stall_valid"}, int'(out_valid), 1);
                    check_eq({tag, "/stall_data"}, int'($signed(out_data)), exp_px[p]);
                    check_eq({tag, "/stall_wt_addr"}, int'(wt_addr), T - 1);
                    check_eq({tag, "/stall_ifm_addr"}, int'(ifm_addr),
                             (p/OW + K - 1) * W + (p%OW + K - 1));
                    check_eq({tag, "/stall_acc"}, int'($signed(pe_inpsum)), exp_px[p]);
                end
                out_ready = 1'b1;
            end
            @(negedge clk);
        end
        check_eq({tag, "/done"}, int'(done), 1);
        check_eq({tag, "/busy_done"}, int'(busy), 0);
        check_eq({tag, "/zero_cnt"}, int'(zero_cnt), exp_zc);
        if (chain) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq({tag, "/done_pulse"}, int'(done), 0);
        check_eq({tag, "/busy_after"}, int'(busy), int'(chain));
    endtask

    initial begin
        int px[NPX];
        int zc;
        for (int i = 0; i < 16; i++) begin
            wt_mem[i]  = 2'b01;
            ifm_mem[i] = 2'b01;
        end
        repeat (2) @(negedge clk);
        check_eq("reset/busy", int'(busy), 0);
        check_eq("reset/done", int'(done), 0);
        check_eq("reset/valid", int'(out_valid), 0);
        check_eq("reset/data", int'($signed(out_data)), 0);
        check_eq("reset/wt_addr", int'(wt_addr), 0);
        check_eq("reset/ifm_addr", int'(ifm_addr), 0);
        check_eq("reset/zc", int'(zero_cnt), 0);
        rst_n = 1'b1;
        @(negedge clk);

        px = '{9, 9, 9, 9};
        run_frame("ones", px, 0, 1'b0, -1, -1, -1, 1'b0);

        for (int i = 0; i < 16; i++) ifm_mem[i] = 2'b00;
        px = '{0, 0, 0, 0};
        run_frame("zeros", px, 36, 1'b0, -1, -1, -1, 1'b0);

        for (int i = 0; i < 16; i++) begin
            wt_mem[i]  = 2'b10;
            ifm_mem[i] = 2'b10;
        end
        px = '{36, 36, 36, 36};
        run_frame("neg2", px, 0, 1'b0, -1, -1, -1, 1'b0);

        for (int i = 0; i < 16; i++) begin
            wt_mem[i]  = 2'b01;
            ifm_mem[i] = 2'((i % 3) - 1);
        end
        px = '{0, 0, 0, 0};
        run_frame("ramp", px, 12, 1'b0, -1, -1, -1, 1'b0);

        for (int i = 0; i < 16; i++) wt_mem[i] = 2'(i % 4);
        for (int p = 0; p < NPX; p++) px[p] = gold_px(p / OW, p % OW);
        zc = gold_zc();
        run_frame("mixed_stall", px, zc, 1'b0, 1, -1, -1, 1'b0);
        run_frame("mixed_rst", px, zc, 1'b0, -1, 2, -1, 1'b0);
        run_frame("mixed_busy_start", px, zc, 1'b0, -1, -1, 1, 1'b1);
        run_frame("mixed_chained", px, zc, 1'b1, -1, -1, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
